adma_desc_feeder: RTL and testbench

Descriptor-side initiator for the DMA engine. Walks an ADMA descriptor table in system memory, fetches each 96-bit descriptor line as three 32-bit reads, and presents transfer descriptors on the DMA command port with a write strobe. It paces issue on the DMA `busy` flag. It resolves NOP and LINK entries locally and signals completion or error to the host-side controller.

---
 rtl/adma_pkg.sv | 51 +++++
 rtl/adma_desc_feeder_if.sv | 28 ++
 rtl/adma_line_asm.sv | 38 +++
 rtl/adma_desc_feeder.sv | 199 +++++++++++++++++++
 tb/tb_adma_desc_feeder.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/adma_pkg.sv
// ============================================================================
// adma_pkg : shared states, act encodings, descriptor layout, error codes
// Revision : 1.0
// ============================================================================
`default_nettype none

package adma_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_FETCH0    = 4'd1,
    ST_FETCH1    = 4'd2,
    ST_FETCH2    = 4'd3,
    ST_DECODE    = 4'd4,
    ST_ISSUE     = 4'd5,
    ST_WAIT_ACK  = 4'd6,
    ST_WAIT_IDLE = 4'd7,
    ST_DONE      = 4'd8,
    ST_ERROR     = 4'd9
  } adma_state_t;

  typedef enum logic [1:0] {
    ACT_NOP  = 2'b00,
    ACT_RSV  = 2'b01,
    ACT_TRAN = 2'b10,
    ACT_LINK = 2'b11
  } adma_act_t;

  localparam int BIT_VALID = 0;
  localparam int BIT_END   = 1;
  localparam int BIT_ACT1  = 4;
  localparam int BIT_ACT2  = 5;
  localparam int LEN_LSB   = 16;
  localparam int LEN_MSB   = 31;
  localparam int ADDR_LSB  = 32;
  localparam int ADDR_MSB  = 95;

  localparam logic [63:0] DESC_STRIDE = 64'd12;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_INVALID = 2'b01;
  localparam logic [1:0] ERR_LOOP    = 2'b10;
  localparam logic [1:0] ERR_DMA     = 2'b11;

  function automatic logic [63:0] fetch_addr(input logic [63:0] ptr, input logic [1:0] idx);
    return ptr + {60'd0, idx, 2'b00};
  endfunction

endpackage

`default_nettype wire

// File: rtl/adma_desc_feeder_if.sv
// ============================================================================
// adma_desc_feeder_if : memory read port and DMA command port of the feeder
// Revision : 1.0
// ============================================================================
`default_nettype none

interface adma_desc_feeder_if;
  logic [63:0] mem_addr_out;
  logic        mem_rd_req;
  logic        mem_rd_ack;
  logic [31:0] mem_data_in;
  logic [95:0] addr_out_COM;
  logic        write_out_COM;
  logic        busy_in_DMA;
  logic        error_in_DMA;

  modport master (
    output mem_addr_out, mem_rd_req, addr_out_COM, write_out_COM,
    input  mem_rd_ack, mem_data_in, busy_in_DMA, error_in_DMA
  );

  modport slave (
    input  mem_addr_out, mem_rd_req, addr_out_COM, write_out_COM,
    output mem_rd_ack, mem_data_in, busy_in_DMA, error_in_DMA
  );
endinterface

`default_nettype wire

// File: rtl/adma_line_asm.sv
// ============================================================================
// adma_line_asm : shifts three 32-bit words into a 96-bit descriptor line
// Revision : 1.0
// ============================================================================
`default_nettype none

module adma_line_asm
  import adma_pkg::*;
(
  input  logic        clk_in_COM,
  input  logic        reset_in_COM,
  input  logic        shift_en,
  input  logic [31:0] word_in,
  output logic [95:0] line_out,
  output logic        valid_out,
  output logic        end_out,
  output adma_act_t   act_out
);

  logic [95:0] r_line;

  // Words enter at the top so word 0 lands in [31:0] after the third shift.
  always_ff @(posedge clk_in_COM) begin
    if (reset_in_COM) begin
      r_line <= '0;
    end else if (shift_en) begin
      r_line <= {word_in, r_line[95:32]};
    end
  end

  assign line_out  = r_line;
  assign valid_out = r_line[BIT_VALID];
  assign end_out   = r_line[BIT_END];
  assign act_out   = adma_act_t'({r_line[BIT_ACT2], r_line[BIT_ACT1]});

endmodule

`default_nettype wire

// File: rtl/adma_desc_feeder.sv
// ============================================================================
// adma_desc_feeder : walks an ADMA descriptor table and issues DMA commands
// Optional LINK following: ADMA_DESC_LINK_EN.  Revision : 1.0
// ============================================================================
`default_nettype none

module adma_desc_feeder
  import adma_pkg::*;
#(
  parameter int MAX_DESC = 64
) (
  input  logic                  clk_in_COM,
  input  logic                  reset_in_COM,
  input  logic                  start_in,
  input  logic [63:0]           desc_base_in,
  adma_desc_feeder_if.master    bus,
  output logic                  done_out,
  output logic                  error_out,
  output logic [1:0]            err_code_out
);

  localparam logic [8:0] c_max_cnt = 9'(MAX_DESC);

  adma_state_t r_state, w_state_nxt;
  logic [63:0] r_ptr;
  logic [8:0]  r_count;
  logic [63:0] r_mem_addr;
  logic        r_mem_rd_req;
  logic [95:0] r_addr_out;
  logic        r_error;
  logic [1:0]  r_err_code;

  logic        w_ack;
  logic        w_in_fetch;
  logic [1:0]  w_word_idx;
  logic [8:0]  w_count_inc;
  logic [1:0]  w_err_nxt;
  logic        w_write;
  logic        w_ptr_step;
`ifdef ADMA_DESC_LINK_EN
  logic        w_ptr_link;
`endif
  logic [95:0] w_line;
  logic        w_valid;
  logic        w_end;
  adma_act_t   w_act;

  assign w_ack       = r_mem_rd_req & bus.mem_rd_ack;
  assign w_count_inc = r_count + 9'd1;

  adma_line_asm u_line_asm (
    .clk_in_COM   (clk_in_COM),
    .reset_in_COM (reset_in_COM),
    .shift_en     (w_ack),
    .word_in      (bus.mem_data_in),
    .line_out     (w_line),
    .valid_out    (w_valid),
    .end_out      (w_end),
    .act_out      (w_act)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_err_nxt   = ERR_NONE;
    w_write     = 1'b0;
    w_ptr_step  = 1'b0;
`ifdef ADMA_DESC_LINK_EN
    w_ptr_link  = 1'b0;
`endif
    w_in_fetch  = 1'b0;
    w_word_idx  = 2'd0;

    case (r_state)
      ST_IDLE:   if (start_in) w_state_nxt = ST_FETCH0;
      ST_FETCH0: begin
        w_in_fetch = 1'b1;
        w_word_idx = 2'd0;
        if (w_ack) w_state_nxt = ST_FETCH1;
      end
      ST_FETCH1: begin
        w_in_fetch = 1'b1;
        w_word_idx = 2'd1;
        if (w_ack) w_state_nxt = ST_FETCH2;
      end
      ST_FETCH2: begin
        w_in_fetch = 1'b1;
        w_word_idx = 2'd2;
        if (w_ack) w_state_nxt = ST_DECODE;
      end
      ST_DECODE: begin
        if (w_count_inc > c_max_cnt) begin
          w_state_nxt = ST_ERROR;
          w_err_nxt   = ERR_LOOP;
        end else if (!w_valid) begin
          w_state_nxt = ST_ERROR;
          w_err_nxt   = ERR_INVALID;
        end else begin
          case (w_act)
            ACT_TRAN: w_state_nxt = ST_ISSUE;
            ACT_LINK: begin
`ifdef ADMA_DESC_LINK_EN
              w_state_nxt = ST_FETCH0;
              w_ptr_link  = 1'b1;
`else
              w_state_nxt = ST_ERROR;
              w_err_nxt   = ERR_DMA;
`endif
            end
            default: begin
              if (w_end) begin
                w_state_nxt = ST_DONE;
              end else begin
                w_state_nxt = ST_FETCH0;
                w_ptr_step  = 1'b1;
              end
            end
          endcase
        end
      end
      ST_ISSUE: begin
        if (!bus.busy_in_DMA) begin
          w_write     = 1'b1;
          w_state_nxt = ST_WAIT_ACK;
        end
      end
      ST_WAIT_ACK:  if (bus.busy_in_DMA) w_state_nxt = ST_WAIT_IDLE;
      ST_WAIT_IDLE: begin
        if (!bus.busy_in_DMA) begin
          if (w_end) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_state_nxt = ST_FETCH0;
            w_ptr_step  = 1'b1;
          end
        end
      end
      ST_DONE:  w_state_nxt = ST_IDLE;
      ST_ERROR: w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase

    // A DMA error overrides whatever the state logic decided this cycle.
    if (r_state != ST_IDLE && bus.error_in_DMA) begin
      w_state_nxt = ST_ERROR;
      w_err_nxt   = ERR_DMA;
      w_write     = 1'b0;
      w_ptr_step  = 1'b0;
`ifdef ADMA_DESC_LINK_EN
      w_ptr_link  = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk_in_COM) begin
    if (reset_in_COM) begin
      r_state      <= ST_IDLE;
      r_ptr        <= '0;
      r_count      <= '0;
      r_mem_addr   <= '0;
      r_mem_rd_req <= 1'b0;
      r_addr_out   <= '0;
      r_error      <= 1'b0;
      r_err_code   <= ERR_NONE;
    end else begin
      r_state <= w_state_nxt;
      // Request rises one cycle after entering a fetch state and drops on the accepting edge.
      r_mem_rd_req <= w_in_fetch && (w_state_nxt == r_state);
      if (w_in_fetch) r_mem_addr <= fetch_addr(r_ptr, w_word_idx);

      if (r_state == ST_IDLE && start_in) begin
        r_ptr      <= desc_base_in;
        r_count    <= '0;
        r_error    <= 1'b0;
        r_err_code <= ERR_NONE;
      end
      if (r_state == ST_DECODE) r_count <= w_count_inc;
      if (w_ptr_step) r_ptr <= r_ptr + DESC_STRIDE;
`ifdef ADMA_DESC_LINK_EN
      if (w_ptr_link) r_ptr <= w_line[ADDR_MSB:ADDR_LSB];
`endif
      if (r_state == ST_DECODE && w_state_nxt == ST_ISSUE) r_addr_out <= w_line;
      if (w_state_nxt == ST_ERROR) begin
        r_error    <= 1'b1;
        r_err_code <= w_err_nxt;
      end
    end
  end

  assign bus.mem_addr_out  = r_mem_addr;
  assign bus.mem_rd_req    = r_mem_rd_req;
  assign bus.addr_out_COM  = r_addr_out;
  assign bus.write_out_COM = w_write;
  assign done_out          = (r_state == ST_DONE);
  assign error_out         = r_error;
  assign err_code_out      = r_err_code;

endmodule

`default_nettype wire

// File: tb/tb_adma_desc_feeder.sv
// ============================================================================
// tb_adma_desc_feeder : directed bench with zero-wait memory and a DMA busy model
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_adma_desc_feeder;

  logic        clk_in_COM = 1'b0;
  logic        reset_in_COM = 1'b1;
  logic        start_in = 1'b0;
  logic [63:0] desc_base_in = '0;
  logic        done_out;
  logic        error_out;
  logic [1:0]  err_code_out;

  adma_desc_feeder_if bus();

  adma_desc_feeder #(.MAX_DESC(4)) dut (
    .clk_in_COM   (clk_in_COM),
    .reset_in_COM (reset_in_COM),
    .start_in     (start_in),
    .desc_base_in (desc_base_in),
    .bus          (bus),
    .done_out     (done_out),
    .error_out    (error_out),
    .err_code_out (err_code_out)
  );

  always #5 clk_in_COM = ~clk_in_COM;

  bit [31:0]   mem [bit [63:0]];
  logic        ack_r = 1'b0;
  logic [31:0] data_r = '0;
  logic        busy_r = 1'b0;
  logic        dma_err = 1'b0;
  assign bus.mem_rd_ack   = ack_r;
  assign bus.mem_data_in  = data_r;
  assign bus.busy_in_DMA  = busy_r;
  assign bus.error_in_DMA = dma_err;

  int cyc = 0;
  always @(posedge clk_in_COM) cyc <= cyc + 1;

  int          strobe_n = 0, rd_n = 0, done_n = 0, ack_used = 0, strobe_cyc = 0;
  int          ack_limit = 1 << 30;
  int          busy_len = 3;
  int          busy_cnt = 0;
  bit          busy_pend = 0;
  logic [95:0] strobe_log [128];
  logic [63:0] rd_log [128];

  // Memory responder and DMA model: observe DUT first, then update stimulus.
  always @(negedge clk_in_COM) begin
    bit w;
    w = bus.write_out_COM;
    if (done_out) done_n++;
    if (w) begin
      if (strobe_n < 128) strobe_log[strobe_n] = bus.addr_out_COM;
      strobe_cyc = cyc;
      strobe_n++;
    end
    if (bus.mem_rd_req && ack_used < ack_limit) begin
      ack_r  = 1'b1;
      data_r = mem.exists(bus.mem_addr_out) ? mem[bus.mem_addr_out] : 32'h0;
      if (rd_n < 128) rd_log[rd_n] = bus.mem_addr_out;
      rd_n++;
      ack_used++;
    end else begin
      ack_r = 1'b0;
    end
    if (busy_pend) begin
      busy_r    = 1'b1;
      busy_cnt  = busy_len;
      busy_pend = 0;
    end else if (busy_cnt > 0) begin
      busy_cnt--;
      if (busy_cnt == 0) busy_r = 1'b0;
    end
    if (w) busy_pend = 1;
  end

  int total = 0, bad = 0;
  int s0_strobe, s0_rd, s0_done, s_cyc;

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic put(input logic [63:0] a, input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2);
    mem[a]       = w0;
    mem[a + 64'd4] = w1;
    mem[a + 64'd8] = w2;
  endtask

  task automatic start_run(input logic [63:0] base);
    @(negedge clk_in_COM);
    s0_strobe    = strobe_n;
    s0_rd        = rd_n;
    s0_done      = done_n;
    desc_base_in = base;
    start_in     = 1'b1;
    s_cyc        = cyc;
    @(negedge clk_in_COM);
    start_in     = 1'b0;
    desc_base_in = '0;
  endtask

  task automatic wait_end(input string tag);
    bit fin;
    fin = 0;
    for (int k = 0; k < 400 && !fin; k++) begin
      if (done_n != s0_done || error_out) fin = 1;
      else @(negedge clk_in_COM);
    end
    chk({tag, "_finished"}, {95'd0, fin}, 96'd1);
    repeat (3) @(negedge clk_in_COM);
  endtask

  initial begin
    repeat (3) @(negedge clk_in_COM);
    reset_in_COM = 1'b0;

    chk("rst_mem_addr", bus.mem_addr_out, 96'd0);
    chk("rst_rd_req", {95'd0, bus.mem_rd_req}, 96'd0);
    chk("rst_addr_out", bus.addr_out_COM, 96'd0);
    chk("rst_write", {95'd0, bus.write_out_COM}, 96'd0);
    chk("rst_done", {95'd0, done_out}, 96'd0);
    chk("rst_error", {95'd0, error_out}, 96'd0);
    chk("rst_code", {94'd0, err_code_out}, 96'd0);

    // Single TRAN+end at 0x1000
    busy_len = 3;
    mem.delete();
    put(64'h1000, 32'h0040_0023, 32'hCAFE_0000, 32'h0000_00AB);
    start_run(64'h1000);
    wait_end("t1");
    chk("t1_strobes", 96'(strobe_n - s0_strobe), 96'd1);
    chk("t1_latency", 96'(strobe_cyc - s_cyc), 96'd8);
    chk("t1_line", strobe_log[s0_strobe], 96'h0000_00AB_CAFE_0000_0040_0023);
    chk("t1_daddr", {32'd0, strobe_log[s0_strobe][95:32]}, 96'h0000_00AB_CAFE_0000);
    chk("t1_rd0", {32'd0, rd_log[s0_rd]}, 96'h1000);
    chk("t1_rd1", {32'd0, rd_log[s0_rd + 1]}, 96'h1004);
    chk("t1_rd2", {32'd0, rd_log[s0_rd + 2]}, 96'h1008);
    chk("t1_done", 96'(done_n - s0_done), 96'd1);
    chk("t1_error", {95'd0, error_out}, 96'd0);

    // Three TRAN entries from 0x0, busy 5 cycles each
    busy_len = 5;
    mem.delete();
    put(64'h00, 32'h0100_0021, 32'hA000_0000, 32'h0);
    put(64'h0C, 32'h0200_0021, 32'hB000_0000, 32'h0);
    put(64'h18, 32'h0300_0023, 32'hC000_0000, 32'h0);
    start_run(64'h0);
    wait_end("t2");
    chk("t2_strobes", 96'(strobe_n - s0_strobe), 96'd3);
    chk("t2_line0", strobe_log[s0_strobe], 96'h0000_0000_A000_0000_0100_0021);
    chk("t2_line1", strobe_log[s0_strobe + 1], 96'h0000_0000_B000_0000_0200_0021);
    chk("t2_line2", strobe_log[s0_strobe + 2], 96'h0000_0000_C000_0000_0300_0023);
    chk("t2_rd_e1", {32'd0, rd_log[s0_rd + 3]}, 96'h0C);
    chk("t2_rd_e2", {32'd0, rd_log[s0_rd + 6]}, 96'h18);
    chk("t2_done", 96'(done_n - s0_done), 96'd1);

    // NOP, LINK to 0x2000, then TRAN+end
    busy_len = 3;
    mem.delete();
    put(64'h3000, 32'h0000_0001, 32'h0, 32'h0);
    put(64'h300C, 32'h0000_0031, 32'h0000_2000, 32'h0);
    put(64'h2000, 32'h0010_0023, 32'h1111_2222, 32'h3333_4444);
    start_run(64'h3000);
    wait_end("t3");
`ifdef ADMA_DESC_LINK_EN
    chk("t3_strobes", 96'(strobe_n - s0_strobe), 96'd1);
    chk("t3_line", strobe_log[s0_strobe], 96'h3333_4444_1111_2222_0010_0023);
    chk("t3_done", 96'(done_n - s0_done), 96'd1);
    chk("t3_error", {95'd0, error_out}, 96'd0);
`else
    chk("t3_strobes", 96'(strobe_n - s0_strobe), 96'd0);
    chk("t3_error", {95'd0, error_out}, 96'd1);
    chk("t3_code", {94'd0, err_code_out}, 96'd3);
    chk("t3_reads", 96'(rd_n - s0_rd), 96'd6);
`endif

    // Invalid descriptor
    mem.delete();
    put(64'h4000, 32'h0000_0022, 32'h1234_5678, 32'h0);
    start_run(64'h4000);
    wait_end("t4");
    chk("t4_error", {95'd0, error_out}, 96'd1);
    chk("t4_code", {94'd0, err_code_out}, 96'd1);
    chk("t4_strobes", 96'(strobe_n - s0_strobe), 96'd0);
    chk("t4_rd_req", {95'd0, bus.mem_rd_req}, 96'd0);

    // Loop limit with MAX_DESC = 4: error after the fifth decode
    mem.delete();
`ifdef ADMA_DESC_LINK_EN
    put(64'h5000, 32'h0000_0031, 32'h0000_5000, 32'h0);
`else
    for (int i = 0; i < 6; i++) put(64'h5000 + 64'(12 * i), 32'h0000_0001, 32'h0, 32'h0);
`endif
    start_run(64'h5000);
    wait_end("t5");
    chk("t5_error", {95'd0, error_out}, 96'd1);
    chk("t5_code", {94'd0, err_code_out}, 96'd2);
    chk("t5_reads", 96'(rd_n - s0_rd), 96'd15);
    chk("t5_done", 96'(done_n - s0_done), 96'd0);

    // DMA error during fetch aborts the run
    mem.delete();
    put(64'h1000, 32'h0040_0023, 32'hCAFE_0000, 32'h0000_00AB);
    start_run(64'h1000);
    repeat (2) @(negedge clk_in_COM);
    dma_err = 1'b1;
    @(negedge clk_in_COM);
    dma_err = 1'b0;
    repeat (2) @(negedge clk_in_COM);
    chk("t6_error", {95'd0, error_out}, 96'd1);
    chk("t6_code", {94'd0, err_code_out}, 96'd3);
    chk("t6_strobes", 96'(strobe_n - s0_strobe), 96'd0);

    // Reset in FETCH1 with the ack outstanding, then a clean rerun
    ack_limit = ack_used + 1;
    start_run(64'h1000);
    repeat (3) @(negedge clk_in_COM);
    chk("t7_pending_req", {95'd0, bus.mem_rd_req}, 96'd1);
    chk("t7_pending_addr", {32'd0, bus.mem_addr_out}, 96'h1004);
    reset_in_COM = 1'b1;
    @(negedge clk_in_COM);
    reset_in_COM = 1'b0;
    ack_limit = 1 << 30;
    chk("t7_rst_mem_addr", {32'd0, bus.mem_addr_out}, 96'd0);
    chk("t7_rst_rd_req", {95'd0, bus.mem_rd_req}, 96'd0);
    chk("t7_rst_addr_out", bus.addr_out_COM, 96'd0);
    chk("t7_rst_error", {95'd0, error_out}, 96'd0);
    chk("t7_rst_code", {94'd0, err_code_out}, 96'd0);
    start_run(64'h1000);
    wait_end("t7");
    chk("t7_rd0", {32'd0, rd_log[s0_rd]}, 96'h1000);
    chk("t7_strobes", 96'(strobe_n - s0_strobe), 96'd1);
    chk("t7_line", strobe_log[s0_strobe], 96'h0000_00AB_CAFE_0000_0040_0023);
    chk("t7_done", 96'(done_n - s0_done), 96'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
